readback_snapshot_mux: RTL

- Parametrised successor to the GPIO readback decoder: exposes N_CH channel pairs, plus timing-test and version words, on two 32-bit GPIO words selected by config_addr.
- Adds address-settle qualification, coherent pair capture, freeze/track mode, a valid flag, a capture sequence tag and a real cycle counter for PS-side timing measurement.
- Sits between the PL monitor signals (Z, Bias, GVP, AD463x, ...) and the PS GPIO readback path.

---
 rtl/rpspmc_readback_pkg.sv | 42 ++++
 rtl/readback_addr_decode.sv | 41 ++++
 rtl/readback_snapshot_mux.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rpspmc_readback_pkg.sv
// Shared constants and types for the PS-side readback snapshot mux.
// Default address map, version words, FSM states and decode kinds.
package rpspmc_readback_pkg;

  localparam logic [31:0] DEF_BASE_ADDR         = 32'd100001;
  localparam logic [31:0] DEF_TIMING_TEST_ADDR  = 32'd101999;
  localparam logic [31:0] DEF_TIMING_RESET_ADDR = 32'd102000;
  localparam logic [31:0] DEF_VERSION_ADDR      = 32'd199997;
  localparam logic [31:0] DEF_VERSION_A         = 32'hEC01_0100;
  localparam logic [31:0] DEF_VERSION_B         = 32'h2025_0301;
  localparam logic [31:0] DEF_UNMAPPED_CODE     = 32'hBAD0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD,
    TRACK
  } rb_state_t;

  typedef enum logic [2:0] {
    SEL_CHANNEL,
    SEL_TIMING_TEST,
    SEL_TIMING_RESET,
    SEL_VERSION,
    SEL_UNMAPPED
  } sel_kind_t;

  // 33-bit window test so a base near 2^32 cannot wrap the upper bound.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input int unsigned n);
    logic [32:0] x;
    logic [32:0] lo;
    logic [32:0] hi;
    x  = {1'b0, a};
    lo = {1'b0, base};
    hi = lo + 33'(n);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/readback_addr_decode.sv
// Combinational classification of the settled readback address into a
// decode kind and, for channel addresses, the channel index.
module readback_addr_decode
  import rpspmc_readback_pkg::*;
#(
  parameter int unsigned N_CH              = 8,
  parameter int unsigned IDX_W             = 3,
  parameter logic [31:0] BASE_ADDR         = DEF_BASE_ADDR,
  parameter logic [31:0] TIMING_TEST_ADDR  = DEF_TIMING_TEST_ADDR,
  parameter logic [31:0] TIMING_RESET_ADDR = DEF_TIMING_RESET_ADDR,
  parameter logic [31:0] VERSION_ADDR      = DEF_VERSION_ADDR
) (
  input  logic [31:0]      addr,
  output sel_kind_t        sel_kind,
  output logic [IDX_W-1:0] ch_index
);

  always_comb begin
    sel_kind = SEL_UNMAPPED;
    ch_index = IDX_W'(addr - BASE_ADDR);
    if (addr == TIMING_RESET_ADDR)
      sel_kind = SEL_TIMING_RESET;
    else if (addr == TIMING_TEST_ADDR)
      sel_kind = SEL_TIMING_TEST;
    else if (addr == VERSION_ADDR)
      sel_kind = SEL_VERSION;
    else if (in_window(addr, BASE_ADDR, N_CH))
      sel_kind = SEL_CHANNEL;
  end

  // Overlapping special addresses still decode by priority, but are flagged.
  if (TIMING_RESET_ADDR == TIMING_TEST_ADDR ||
      TIMING_RESET_ADDR == VERSION_ADDR ||
      TIMING_TEST_ADDR == VERSION_ADDR ||
      in_window(TIMING_RESET_ADDR, BASE_ADDR, N_CH) ||
      in_window(TIMING_TEST_ADDR, BASE_ADDR, N_CH) ||
      in_window(VERSION_ADDR, BASE_ADDR, N_CH)) begin : g_overlap
    $warning("readback_addr_decode: readback addresses overlap");
  end

endmodule

// File: rtl/readback_snapshot_mux.sv
// GPIO readback mux with address-settle qualification, coherent A/B pair
// capture, freeze/track mode, capture tag and a PS-visible cycle counter.
module readback_snapshot_mux
  import rpspmc_readback_pkg::*;
#(
  parameter int unsigned   N_CH              = 8,
  parameter int unsigned   DW                = 32,
  parameter logic [31:0]   BASE_ADDR         = DEF_BASE_ADDR,
  parameter logic [31:0]   TIMING_TEST_ADDR  = DEF_TIMING_TEST_ADDR,
  parameter logic [31:0]   TIMING_RESET_ADDR = DEF_TIMING_RESET_ADDR,
  parameter logic [31:0]   VERSION_ADDR      = DEF_VERSION_ADDR,
  parameter logic [DW-1:0] VERSION_A         = DW'(DEF_VERSION_A),
  parameter logic [DW-1:0] VERSION_B         = DW'(DEF_VERSION_B),
  parameter int unsigned   SETTLE_CYC        = 4,
  parameter bit            FREEZE            = 1'b0,
  parameter logic [DW-1:0] UNMAPPED_CODE     = DW'(DEF_UNMAPPED_CODE)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [31:0]        config_addr,
  input  logic [N_CH*DW-1:0] rb_a,
  input  logic [N_CH*DW-1:0] rb_b,
  output logic [DW-1:0]      gpio_dataA,
  output logic [DW-1:0]      gpio_dataB,
  output logic               rb_valid,
  output logic [15:0]        rb_seq
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("readback_snapshot_mux: SETTLE_CYC must be >= 1");
  end

  rb_state_t        state, state_n;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cyc_cnt;

  logic             load_addr;
  logic             cnt_inc;
  logic             do_load;
  logic             first_cap;

  sel_kind_t        sel_kind;
  logic [IDX_W-1:0] ch_index;
  logic [DW-1:0]    dec_a, dec_b;
  logic [DW-1:0]    a_words [N_CH];
  logic [DW-1:0]    b_words [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign a_words[k] = rb_a[k*DW +: DW];
    assign b_words[k] = rb_b[k*DW +: DW];
  end

  readback_addr_decode #(
    .N_CH              (N_CH),
    .IDX_W             (IDX_W),
    .BASE_ADDR         (BASE_ADDR),
    .TIMING_TEST_ADDR  (TIMING_TEST_ADDR),
    .TIMING_RESET_ADDR (TIMING_RESET_ADDR),
    .VERSION_ADDR      (VERSION_ADDR)
  ) u_decode (
    .addr     (addr_q),
    .sel_kind (sel_kind),
    .ch_index (ch_index)
  );

  always_comb begin
    dec_a = UNMAPPED_CODE;
    dec_b = DW'(addr_q);
    case (sel_kind)
      SEL_CHANNEL: begin
        dec_a = a_words[ch_index];
        dec_b = b_words[ch_index];
      end
      SEL_TIMING_RESET: begin
        dec_a = '0;
        dec_b = '0;
      end
      SEL_TIMING_TEST: begin
        dec_a = DW'(cyc_cnt);
        dec_b = gpio_dataA;
      end
      SEL_VERSION: begin
        dec_a = VERSION_A;
        dec_b = VERSION_B;
      end
      default: ;
    endcase
  end

  // An address change always wins, including on the capture edge.
  always_comb begin
    state_n   = state;
    load_addr = 1'b0;
    cnt_inc   = 1'b0;
    do_load   = 1'b0;
    first_cap = 1'b0;
    case (state)
      IDLE: begin
        load_addr = 1'b1;
        state_n   = SETTLE;
      end
      SETTLE: begin
        if (config_addr != addr_q)
          load_addr = 1'b1;
        else if (cnt == CNT_W'(SETTLE_CYC - 1))
          state_n = CAPTURE;
        else
          cnt_inc = 1'b1;
      end
      CAPTURE: begin
        if (config_addr != addr_q) begin
          load_addr = 1'b1;
          state_n   = SETTLE;
        end else begin
          do_load   = 1'b1;
          first_cap = 1'b1;
          state_n   = FREEZE ? HOLD : TRACK;
        end
      end
      HOLD, TRACK: begin
        if (config_addr != addr_q) begin
          load_addr = 1'b1;
          state_n   = SETTLE;
        end else if (state == TRACK) begin
          do_load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q     <= '0;
      cnt        <= '0;
      cyc_cnt    <= '0;
      gpio_dataA <= '0;
      gpio_dataB <= '0;
      rb_valid   <= 1'b0;
      rb_seq     <= '0;
    end else begin
      cyc_cnt <= (do_load && sel_kind == SEL_TIMING_RESET) ? 32'd0 : cyc_cnt + 32'd1;
      if (load_addr) begin
        addr_q   <= config_addr;
        cnt      <= '0;
        rb_valid <= 1'b0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (do_load) begin
        gpio_dataA <= dec_a;
        gpio_dataB <= dec_b;
        rb_valid   <= 1'b1;
      end
      if (first_cap)
        rb_seq <= rb_seq + 16'd1;
    end
  end

endmodule
